// File: rtl/framebuffer_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_writer
//   Upstream stage of the VGA display path. Takes a raster stream of grey
//   pixels (valid/ready with start-of-frame and end-of-line markers), keeps
//   the top two bits of each pixel and writes them into the framebuffer at
//   the linear address row*FB_WIDTH+col. The address is an incrementing
//   counter plus a per-line base register.
//
// Ports
//   vga_clk_25   in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   capture_en   in   level, 1 = capture frames continuously
//   pix_data     in   input pixel
//   pix_valid    in   pix_data/pix_sof/pix_eol valid this cycle
//   pix_sof      in   beat is first pixel of a frame
//   pix_eol      in   beat is last pixel of a line
//   pix_ready    out  block accepts a beat this cycle
//   wr_en        out  framebuffer write strobe (1 cycle after the beat)
//   wr_addr      out  framebuffer write address
//   wr_data      out  quantised pixel
//   frame_done   out  1-cycle pulse, full frame written
//   frame_count  out  completed frames, wraps 255 -> 0
//   line_err     out  sticky, a line was short or long
//   frame_err    out  sticky, sof arrived mid-frame
//   err_clr      in   synchronous clear of line_err/frame_err
//   dbg_state    out  current FSM state (0 IDLE, 1 WAIT_SOF, 2 CAPTURE)
//
// Handshake: a beat is transferred on a rising edge where pix_valid and
// pix_ready are both 1. pix_ready depends only on the FSM state, never on
// pix_valid, and pix_valid=0 cycles leave all state untouched.
// -----------------------------------------------------------------------------
module framebuffer_writer #(
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int IN_WIDTH   = 8
) (
  input  logic                  vga_clk_25,
  input  logic                  reset_n,
  input  logic                  capture_en,
  input  logic [IN_WIDTH-1:0]   pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  output logic                  pix_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [1:0]            wr_data,
  output logic                  frame_done,
  output logic [7:0]            frame_count,
  output logic                  line_err,
  output logic                  frame_err,
  input  logic                  err_clr,
  output logic [1:0]            dbg_state
);

  localparam int COL_W = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
  localparam int ROW_W = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
  localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(FB_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW   = ROW_W'(FB_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_PITCH = ADDR_WIDTH'(FB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_ready;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [ADDR_WIDTH-1:0]   r_addr;       // address of the next pixel
  logic [ADDR_WIDTH-1:0]   r_base;       // address of column 0 of the current line
  logic                    r_drop;       // long line: discard beats up to eol
  logic                    r_wr_en;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [1:0]              r_wr_data;
  logic                    r_frame_done;
  logic [7:0]              r_frame_count;
  logic                    r_line_err;
  logic                    r_frame_err;

  logic       w_beat;
  logic [1:0] w_qdata;
  logic       w_unused_pix;

  assign w_beat       = pix_valid & r_ready;
  assign w_qdata      = pix_data[IN_WIDTH-1 -: 2];
  assign w_unused_pix = ^pix_data[IN_WIDTH-3:0];

  always_ff @(posedge vga_clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_addr        <= '0;
      r_base        <= '0;
      r_drop        <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (capture_en) begin
            r_state <= S_WAIT_SOF;
            r_ready <= 1'b1;
          end
        end
        default: begin
          if (w_beat && pix_sof) begin
            // A sof always (re)starts the frame at pixel (0,0); inside
            // CAPTURE it means the previous frame was cut short.
            if (r_state == S_CAPTURE) r_frame_err <= 1'b1;
            r_state   <= S_CAPTURE;
            r_drop    <= 1'b0;
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= w_qdata;
            if (pix_eol) begin
              // One-pixel line: short-line rule, next line starts at row 1.
              r_line_err <= 1'b1;
              r_row      <= ROW_W'(1);
              r_col      <= '0;
              r_base     <= LINE_PITCH;
              r_addr     <= LINE_PITCH;
            end else begin
              r_row  <= '0;
              r_col  <= COL_W'(1);
              r_base <= '0;
              r_addr <= ADDR_WIDTH'(1);
            end
          end else if (r_state == S_WAIT_SOF) begin
            // Non-sof beats are accepted and discarded here.
            if (!capture_en) begin
              r_state <= S_IDLE;
              r_ready <= 1'b0;
            end
          end else if (w_beat) begin
            if (!r_drop) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_qdata;
            end else if (r_col == LAST_COL) begin
              // First extra beat of a long line.
              r_line_err <= 1'b1;
            end
            if (pix_eol) begin
              if (!r_drop && r_col != LAST_COL) r_line_err <= 1'b1;
              r_drop <= 1'b0;
              if (r_row == LAST_ROW) begin
                r_frame_done  <= 1'b1;
                r_frame_count <= r_frame_count + 8'd1;
                r_row         <= '0;
                r_col         <= '0;
                r_base        <= '0;
                r_addr        <= '0;
                if (capture_en) begin
                  r_state <= S_WAIT_SOF;
                end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b0;
                end
              end else begin
                // Short lines skip the rest of their addresses.
                r_row  <= r_row + ROW_W'(1);
                r_col  <= '0;
                r_base <= r_base + LINE_PITCH;
                r_addr <= r_base + LINE_PITCH;
              end
            end else if (r_drop) begin
              // Column is meaningless while dropping; moving it off the last
              // column marks that the first extra beat has been seen.
              r_col <= '0;
            end else if (r_col == LAST_COL) begin
              r_drop <= 1'b1;
            end else begin
              r_col  <= r_col + COL_W'(1);
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
      endcase
      // Clear wins over any error set in the same cycle.
      if (err_clr) begin
        r_line_err  <= 1'b0;
        r_frame_err <= 1'b0;
      end
    end
  end

  assign pix_ready   = r_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_framebuffer_writer.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_writer
//   Drives a reduced 40x24 framebuffer geometry with random pixel streams.
//   The reference model counts beats per line and computes addresses as
//   row*W+col; expected writes (with the cycle they must appear in) go into
//   exp_q and a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_framebuffer_writer;
  localparam int W  = 40;
  localparam int H  = 24;
  localparam int AW = 10;
  localparam int EW = 32 + 1 + AW + 2;

  // ---------------- clock / reset ----------------
  logic vga_clk_25 = 1'b0;
  logic reset_n    = 1'b0;
  always #20 vga_clk_25 = ~vga_clk_25;

  int cyc = 0;
  always @(posedge vga_clk_25) cyc <= cyc + 1;

  logic          capture_en = 1'b0;
  logic [7:0]    pix_data   = 8'd0;
  logic          pix_valid  = 1'b0;
  logic          pix_sof    = 1'b0;
  logic          pix_eol    = 1'b0;
  logic          err_clr    = 1'b0;
  logic          pix_ready, wr_en, frame_done, line_err, frame_err;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data, dbg_state;
  logic [7:0]    frame_count;

  framebuffer_writer #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(AW), .IN_WIDTH(8)
  ) dut (
    .vga_clk_25 (vga_clk_25),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_ready  (pix_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .err_clr    (err_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int done_seen = 0;

  // reference model
  bit         m_in_frame  = 0;
  int         m_row       = 0;
  int         m_col       = 0;   // beats seen so far in the current line
  logic       m_line_err  = 0;
  logic       m_frame_err = 0;
  logic [7:0] m_count     = 0;
  int         m_dones     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of one accepted beat.
  task automatic model_beat(input logic [7:0] d, input logic sof, input logic eol);
    logic done;
    if (sof) begin
      if (m_in_frame) m_frame_err = 1'b1;
      m_in_frame = 1;
      m_row = 0;
      m_col = 0;
    end
    if (m_in_frame) begin
      done = eol && (m_row == H - 1);
      if (m_col < W)
        exp_q.push_back({32'(cyc + 1), done, AW'(m_row * W + m_col), d[7:6]});
      if (m_col == W) m_line_err = 1'b1;
      if (eol) begin
        if (m_col < W - 1) m_line_err = 1'b1;
        if (done) begin
          m_in_frame = 0;
          m_count    = m_count + 8'd1;
          m_dones++;
        end else begin
          m_row++;
          m_col = 0;
        end
      end else begin
        m_col++;
      end
    end
    if (err_clr) begin
      m_line_err  = 1'b0;
      m_frame_err = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge vga_clk_25) begin
    if (reset_n) begin
      if (frame_done) begin
        done_seen++;
        if (!wr_en) check("done_with_write", 64'(wr_en), 64'd1);
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", wr_addr, wr_data);
        end else begin
          check("write{cycle,done,addr,data}",
                64'({32'(cyc), frame_done, wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    repeat (n) @(negedge vga_clk_25);
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!pix_ready && t < 16) begin
      @(negedge vga_clk_25);
      t++;
    end
    if (!pix_ready) check("pix_ready_timeout", 64'(pix_ready), 64'd1);
  endtask

  task automatic send_line(input int row, input int n, input bit sof, input bit eol,
                           input int max_gap, input bit pattern);
    int gap;
    logic [7:0] d;
    for (int c = 0; c < n; c++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      d   = pattern ? 8'((row * 16) ^ (c * 7)) : 8'($urandom_range(0, 255));
      repeat (gap) begin
        pix_valid = 1'b0;
        pix_data  = 8'($urandom_range(0, 255));
        pix_sof   = 1'($urandom_range(0, 1));
        pix_eol   = 1'($urandom_range(0, 1));
        @(negedge vga_clk_25);
      end
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = sof && (c == 0);
      pix_eol   = eol && (c == n - 1);
      wait_ready();
      model_beat(d, pix_sof, pix_eol);
      @(negedge vga_clk_25);
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic send_rows(input int first, input int last, input int max_gap, input bit pattern);
    for (int r = first; r <= last; r++) send_line(r, W, r == 0, 1'b1, max_gap, pattern);
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    m_line_err  = 1'b0;
    m_frame_err = 1'b0;
    @(negedge vga_clk_25);
    err_clr = 1'b0;
  endtask

  task automatic check_status(input string tag);
    idle(4);
    check({tag, ":line_err"},    64'(line_err),     64'(m_line_err));
    check({tag, ":frame_err"},   64'(frame_err),    64'(m_frame_err));
    check({tag, ":frame_count"}, 64'(frame_count),  64'(m_count));
    check({tag, ":frame_done"},  64'(done_seen),    64'(m_dones));
    check({tag, ":pending"},     64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":outputs"},
          64'({pix_ready, wr_en, wr_addr, wr_data, frame_done, frame_count,
               line_err, frame_err, dbg_state}), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge vga_clk_25);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(3);
    check("idle_ready", 64'(pix_ready), 64'd0);

    // 1: full frame, back to back, patterned data
    capture_en = 1'b1;
    idle(2);
    check("wait_sof_ready", 64'(pix_ready), 64'd1);
    send_rows(0, H - 1, 0, 1'b1);
    check_status("full_frame");

    // 2: same frame with random stalls and junk on invalid cycles
    send_rows(0, H - 1, 3, 1'b1);
    check_status("gapped_frame");

    // 3: junk before sof, short row 5, long row 7
    send_line(0, 3, 1'b0, 1'b0, 1, 1'b0);
    send_rows(0, 4, 1, 1'b0);
    send_line(5, 10, 1'b0, 1'b1, 1, 1'b0);
    send_line(6, W, 1'b0, 1'b1, 1, 1'b0);
    send_line(7, W + 10, 1'b0, 1'b1, 1, 1'b0);
    send_rows(8, H - 1, 1, 1'b0);
    check_status("short_long");
    clear_errs();
    check_status("short_long_clr");

    // 4: sof mid-frame restarts; only the restarted frame completes
    send_rows(0, 9, 0, 1'b0);
    send_line(10, 7, 1'b0, 1'b0, 0, 1'b0);
    send_rows(0, H - 1, 2, 1'b0);
    check_status("sof_restart");
    clear_errs();
    check_status("sof_restart_clr");

    // 5: sof and eol on the same beat, then err_clr colliding with an error
    send_line(0, 1, 1'b1, 1'b1, 0, 1'b0);
    send_rows(1, H - 1, 0, 1'b0);
    check_status("sof_eol");
    clear_errs();
    send_rows(0, 2, 0, 1'b0);
    err_clr = 1'b1;
    send_line(3, 5, 1'b0, 1'b1, 0, 1'b0);
    err_clr = 1'b0;
    send_rows(4, H - 1, 0, 1'b0);
    check_status("clr_priority");

    // 6: capture_en dropped mid-frame; frame finishes then block goes idle
    send_rows(0, 19, 1, 1'b0);
    capture_en = 1'b0;
    send_rows(20, H - 1, 1, 1'b0);
    check_status("capture_off");
    check("capture_off:ready", 64'(pix_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1;
      pix_sof   = 1'b1;
      pix_eol   = 1'($urandom_range(0, 1));
      pix_data  = 8'($urandom_range(0, 255));
      @(negedge vga_clk_25);
    end
    idle(3);
    check("capture_off:still_idle", 64'(pix_ready), 64'd0);

    // Asynchronous reset in the middle of a frame
    capture_en = 1'b1;
    idle(2);
    send_rows(0, 2, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    m_in_frame  = 0;
    m_line_err  = 1'b0;
    m_frame_err = 1'b0;
    m_count     = 8'd0;
    @(negedge vga_clk_25);
    reset_n = 1'b1;
    idle(3);
    check("after_reset:ready", 64'(pix_ready), 64'd1);
    check_status("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
